// File: rtl/apb_ram_pkg.sv
// Shared types and sizing helpers for the APB RAM slave with wait states.
package apb_ram_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_ALIGN,
    ERR_RANGE,
    ERR_PROT
  } err_cause_t;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_ram_ws_if.sv
// APB4 bus bundle between a bus-matrix master port and the RAM slave.
interface apb_ram_ws_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_W-1:0]     PSTRB;
  logic [2:0]            PPROT;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_ram_mem.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module apb_ram_mem
  import apb_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512,
  localparam int STRB_W    = strb_w(DATA_WIDTH),
  localparam int IDX_W     = idx_w(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [STRB_W-1:0]     be_i,
  input  logic [IDX_W-1:0]      addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_ram_ws.sv
// APB4 slave over a byte-strobed RAM with programmable wait states and
// alignment / range / protection error reporting.
module apb_ram_ws
  import apb_ram_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 16,
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = 512,
  parameter int          WAIT_STATES = 0,
  parameter logic [2:0]  MY_PROT     = 3'b000,
  parameter logic [2:0]  PROT_MASK   = 3'b000
) (
  input  logic          PCLK,
  input  logic          PRESET,
  apb_ram_ws_if.slave   apb
);

  localparam int STRB_W = strb_w(DATA_WIDTH);
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = idx_w(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_L = ADDR_WIDTH'(DEPTH);
  localparam logic [3:0]            WS_L    = 4'(WAIT_STATES);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic                  rd_vld_q, rd_vld_d;
  err_cause_t            cause_q, cause_d;
  logic                  wr_q, wr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;

  logic [ADDR_WIDTH-1:0] widx;
  err_cause_t            cause_in;
  logic                  setup, complete;
  logic                  mem_we, mem_re;
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign widx     = apb.PADDR >> OFF_W;
  assign setup    = apb.PSEL & ~apb.PENABLE;
  assign complete = apb.PSEL & apb.PENABLE & pready_q;

  // Alignment outranks range, which outranks protection, when reporting the cause.
  always_comb begin
    cause_in = ERR_NONE;
    if (((apb.PPROT ^ MY_PROT) & PROT_MASK) != 3'b000) cause_in = ERR_PROT;
    if (widx >= DEPTH_L)                                cause_in = ERR_RANGE;
    if (apb.PADDR[OFF_W-1:0] != '0)                     cause_in = ERR_ALIGN;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    rd_vld_d  = rd_vld_q;
    cause_d   = cause_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_idx   = idx_q;
    case (state_q)
      IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        rd_vld_d  = 1'b0;
        mem_idx   = widx[IDX_W-1:0];
        if (setup) begin
          state_d = ACCESS;
          cnt_d   = WS_L;
          cause_d = cause_in;
          wr_d    = apb.PWRITE;
          idx_d   = widx[IDX_W-1:0];
          wdata_d = apb.PWDATA;
          strb_d  = apb.PSTRB;
          if (WS_L == 4'd0) begin
            pready_d  = 1'b1;
            pslverr_d = (cause_in != ERR_NONE);
            if (!apb.PWRITE && cause_in == ERR_NONE) begin
              mem_re   = 1'b1;
              rd_vld_d = 1'b1;
            end
          end
        end
      end
      ACCESS: begin
        if (!apb.PSEL) begin
          state_d   = IDLE;
          cnt_d     = 4'd0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          rd_vld_d  = 1'b0;
        end else if (complete) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          rd_vld_d  = 1'b0;
          mem_we    = wr_q && (cause_q == ERR_NONE);
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = (cause_q != ERR_NONE);
            if (!wr_q && cause_q == ERR_NONE) begin
              mem_re   = 1'b1;
              rd_vld_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  // Captured transfer fields only matter inside ACCESS, so they need no reset.
  always_ff @(posedge PCLK) begin
    cause_q <= cause_d;
    wr_q    <= wr_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    strb_q  <= strb_d;
  end

  apb_ram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_i   (PCLK),
    .we_i    (mem_we & ~PRESET),
    .re_i    (mem_re & ~PRESET),
    .be_i    (strb_q),
    .addr_i  (mem_idx),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign apb.PRDATA  = rd_vld_q ? mem_rdata : '0;

endmodule

// File: tb/tb_apb_ram_ws.sv
// Scoreboard bench for apb_ram_ws: three instances (no wait, 3 waits, 1 wait + PPROT check).
module tb_apb_ram_ws;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;

  logic PCLK = 1'b0;
  logic PRESET;
  always #5 PCLK = ~PCLK;

  logic          psel    [3];
  logic          penable [3];
  logic          pwrite  [3];
  logic [AW-1:0] paddr   [3];
  logic [DW-1:0] pwdata  [3];
  logic [SW-1:0] pstrb   [3];
  logic [2:0]    pprot   [3];
  logic          pready  [3];
  logic          pslverr [3];
  logic [DW-1:0] prdata  [3];

  apb_ram_ws_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_bus
    assign bus[g].PSEL    = psel[g];
    assign bus[g].PENABLE = penable[g];
    assign bus[g].PWRITE  = pwrite[g];
    assign bus[g].PADDR   = paddr[g];
    assign bus[g].PWDATA  = pwdata[g];
    assign bus[g].PSTRB   = pstrb[g];
    assign bus[g].PPROT   = pprot[g];
    assign pready[g]      = bus[g].PREADY;
    assign pslverr[g]     = bus[g].PSLVERR;
    assign prdata[g]      = bus[g].PRDATA;
  end

  apb_ram_ws #(.WAIT_STATES(0)) dut0 (.PCLK(PCLK), .PRESET(PRESET), .apb(bus[0]));
  apb_ram_ws #(.WAIT_STATES(3)) dut1 (.PCLK(PCLK), .PRESET(PRESET), .apb(bus[1]));
  apb_ram_ws #(.WAIT_STATES(1), .MY_PROT(3'b001), .PROT_MASK(3'b001))
    dut2 (.PCLK(PCLK), .PRESET(PRESET), .apb(bus[2]));

  typedef struct {
    bit          wr;
    logic [31:0] rdata;
    logic        err;
    int          len;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One full transfer; address/data are scrambled after setup to prove capture.
  task automatic xfer(input int d, input bit wr, input logic [15:0] addr,
                      input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                      input logic [31:0] erd, input bit eerr, input int elen);
    exp_t e;
    exp_t o;
    int   cyc;
    e.wr = wr; e.rdata = erd; e.err = eerr; e.len = elen;
    sb.push_back(e);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = wd; pstrb[d] = st; pprot[d] = pr;
    @(posedge PCLK); #1;
    penable[d] = 1'b1;
    paddr[d]   = 16'($urandom);
    pwdata[d]  = $urandom;
    cyc = 1;
    while (!pready[d] && cyc < 40) begin
      @(posedge PCLK); #1;
      cyc++;
    end
    o = sb.pop_front();
    chk($sformatf("len d%0d a%0h", d, addr), 32'(cyc + 1), 32'(o.len));
    chk($sformatf("pslverr d%0d a%0h", d, addr), {31'b0, pslverr[d]}, {31'b0, o.err});
    if (!o.wr) chk($sformatf("prdata d%0d a%0h", d, addr), prdata[d], o.rdata);
    @(posedge PCLK); #1;
    chk($sformatf("pready_drop d%0d", d), {31'b0, pready[d]}, 32'd0);
    chk($sformatf("prdata_clr d%0d", d), prdata[d], 32'd0);
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  initial begin
    int hi;
    for (int i = 0; i < 3; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = '0;
      pwdata[i] = '0; pstrb[i] = '0; pprot[i] = '0;
    end
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_pready d%0d", i), {31'b0, pready[i]}, 32'd0);
      chk($sformatf("rst_pslverr d%0d", i), {31'b0, pslverr[i]}, 32'd0);
      chk($sformatf("rst_prdata d%0d", i), prdata[i], 32'd0);
    end
    PRESET = 1'b0;

    // No wait states: basic, strobes, zero strobe, errors, last word.
    xfer(0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b000, 32'h0, 0, 2);
    xfer(0, 0, 16'h0010, 32'h0, 4'hF, 3'b000, 32'hDEADBEEF, 0, 2);
    xfer(0, 1, 16'h0020, 32'h11223344, 4'hF, 3'b000, 32'h0, 0, 2);
    xfer(0, 1, 16'h0020, 32'hAABBCCDD, 4'b0101, 3'b000, 32'h0, 0, 2);
    xfer(0, 0, 16'h0020, 32'h0, 4'h0, 3'b000, 32'h11BB33DD, 0, 2);
    xfer(0, 1, 16'h0020, 32'hFFFFFFFF, 4'h0, 3'b000, 32'h0, 0, 2);
    xfer(0, 0, 16'h0020, 32'h0, 4'hF, 3'b000, 32'h11BB33DD, 0, 2);
    xfer(0, 1, 16'h0000, 32'hCAFEF00D, 4'hF, 3'b000, 32'h0, 0, 2);
    xfer(0, 1, 16'h0800, 32'h0BADBAD0, 4'hF, 3'b000, 32'h0, 1, 2);
    xfer(0, 0, 16'h0800, 32'h0, 4'hF, 3'b000, 32'h0, 1, 2);
    xfer(0, 1, 16'h0002, 32'h12345678, 4'hF, 3'b000, 32'h0, 1, 2);
    xfer(0, 0, 16'h0002, 32'h0, 4'hF, 3'b000, 32'h0, 1, 2);
    xfer(0, 0, 16'h0000, 32'h0, 4'hF, 3'b000, 32'hCAFEF00D, 0, 2);
    xfer(0, 1, 16'h07FC, 32'h5A5AA5A5, 4'hF, 3'b000, 32'h0, 0, 2);
    xfer(0, 0, 16'h07FC, 32'h0, 4'hF, 3'b000, 32'h5A5AA5A5, 0, 2);

    // Three wait states.
    xfer(1, 1, 16'h0010, 32'h0F0F1234, 4'hF, 3'b000, 32'h0, 0, 5);
    xfer(1, 0, 16'h0010, 32'h0, 4'hF, 3'b000, 32'h0F0F1234, 0, 5);
    xfer(1, 1, 16'h0030, 32'h55667788, 4'hF, 3'b000, 32'h0, 0, 5);

    // Reset in the middle of a waited write.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 16'h0030;
    pwdata[1] = 32'h99999999; pstrb[1] = 4'hF; pprot[1] = 3'b000;
    @(posedge PCLK); #1;
    penable[1] = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    chk("rst_mid_pready", {31'b0, pready[1]}, 32'd0);
    hi = 0;
    repeat (6) begin
      @(posedge PCLK); #1;
      hi += int'(pready[1]);
    end
    chk("rst_mid_idle", 32'(hi), 32'd0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge PCLK); #1;
    xfer(1, 0, 16'h0030, 32'h0, 4'hF, 3'b000, 32'h55667788, 0, 5);

    // PSEL dropped during the access phase aborts the write.
    xfer(1, 1, 16'h0040, 32'h01010101, 4'hF, 3'b000, 32'h0, 0, 5);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 16'h0040;
    pwdata[1] = 32'h7E7E7E7E; pstrb[1] = 4'hF;
    @(posedge PCLK); #1;
    penable[1] = 1'b1;
    @(posedge PCLK); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge PCLK); #1;
    chk("abort_pready", {31'b0, pready[1]}, 32'd0);
    xfer(1, 0, 16'h0040, 32'h0, 4'hF, 3'b000, 32'h01010101, 0, 5);

    // One wait state with PPROT[0] required.
    xfer(2, 1, 16'h0050, 32'h01020304, 4'hF, 3'b001, 32'h0, 0, 3);
    xfer(2, 1, 16'h0050, 32'hFFFFFFFF, 4'hF, 3'b000, 32'h0, 1, 3);
    xfer(2, 0, 16'h0050, 32'h0, 4'hF, 3'b001, 32'h01020304, 0, 3);
    xfer(2, 0, 16'h0050, 32'h0, 4'hF, 3'b000, 32'h0, 1, 3);
    xfer(2, 0, 16'h0050, 32'h0, 4'hF, 3'b111, 32'h01020304, 0, 3);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
